// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state and owner encodings for mem_port_arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;
   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;
endpackage

// File: rtl/arb_prio_sel.sv
// arb_prio_sel: data-first priority select; force_i hands the grant to a waiting fetch
module arb_prio_sel (
   input  logic i_req,
   input  logic d_req,
   input  logic force_i,
   output logic grant_i,
   output logic grant_d
);
   assign grant_d = d_req & ~(force_i & i_req);
   assign grant_i = i_req & ~grant_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (i_*) and data (d_*); optional ARB_ANTISTARVE_EN forces fetch after STARVE_LIMIT data grants
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   output logic          i_done,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_done,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          busy
);
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("STARVE_LIMIT must be in 1..15");
   end
   state_e        state_q, state_d;
   owner_e        owner_q, owner_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] i_rdata_q, i_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          i_done_q, i_done_d;
   logic          d_done_q, d_done_d;
   logic          busy_q, busy_d;
   logic          force_i, grant_i, grant_d;
   arb_prio_sel u_sel (
      .i_req   (i_req),
      .d_req   (d_req),
      .force_i (force_i),
      .grant_i (grant_i),
      .grant_d (grant_d)
   );
`ifdef ARB_ANTISTARVE_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   logic [3:0] starve_cnt_q, starve_cnt_d;
   assign force_i = i_req & (starve_cnt_q == LIMIT);
   // counts data grants that overtook a waiting fetch; saturates at LIMIT
   always_comb begin
      starve_cnt_d = (state_q != IDLE) ? starve_cnt_q :
                     grant_i ? 4'd0 :
                     (grant_d & i_req & (starve_cnt_q != LIMIT)) ? starve_cnt_q + 4'd1 : starve_cnt_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) starve_cnt_q <= 4'd0;
      else        starve_cnt_q <= starve_cnt_d;
   end
`else
   assign force_i = 1'b0;
`endif
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_done_d    = 1'b0;
      d_done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d     = ACCESS;
               owner_d     = OWN_D;
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
            end else if (grant_i) begin
               state_d     = ACCESS;
               owner_d     = OWN_I;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = i_addr;
               mem_wdata_d = '0;
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               if (owner_q == OWN_D) begin
                  d_done_d  = 1'b1;
                  d_rdata_d = mem_we_q ? d_rdata_q : mem_rdata;
               end else begin
                  i_done_d  = 1'b1;
                  i_rdata_d = mem_rdata;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_I;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_done_q    <= 1'b0;
         d_done_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_done_q    <= i_done_d;
         d_done_q    <= d_done_d;
         busy_q      <= busy_d;
      end
   end
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign i_done    = i_done_q;
   assign d_done    = d_done_q;
   assign busy      = busy_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified instruction/data memory between two requesters: the Fetch stage (read-only) and the Memory stage (load/store) of the pipelined core. Data requests win by default because they belong to the older instruction. The block registers the winning command, holds it on the memory port until the memory acknowledges it, and returns read data with a one-cycle done pulse. The hazard unit uses `i_req & ~i_done` and `d_req & ~d_done` to stall the relevant stages.

Parameters:
AW, 32, address width.
DW, 32, data width.
STARVE_LIMIT, 4, number of consecutive data grants, while a fetch is waiting, after which fetch is forced to win. Used only with ARB_ANTISTARVE_EN. Legal range 1..15.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
i_req  in  1  fetch request; held until i_done is sampled.
i_addr  in  AW  fetch address; stable while i_req is high.
i_rdata  out  DW  fetch read data; valid while i_done=1.
i_done  out  1  one-cycle completion pulse for fetch.
d_req  in  1  data request; held until d_done is sampled.
d_we  in  1  1 = store, 0 = load.
d_addr  in  AW  data address.
d_wdata  in  DW  store data.
d_rdata  out  DW  load data; valid while d_done=1.
d_done  out  1  one-cycle completion pulse for data.
mem_req  out  1  memory command valid.
mem_we  out  1  memory write enable.
mem_addr  out  AW  memory address.
mem_wdata  out  DW  memory write data.
mem_rdata  in  DW  memory read data; valid in the mem_ack cycle.
mem_ack  in  1  memory completion; sampled only while mem_req=1.
busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; starve_cnt=0.
- Reset mid-transaction abandons the transaction and drops mem_req immediately. The memory must tolerate this.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If d_req=1 (and fetch is not forced): latch {d_we, d_addr, d_wdata}, owner=D, go to ACCESS.
  - Else if i_req=1: latch {0, i_addr, 0}, owner=I, go to ACCESS.
  - Else stay in IDLE.
- ACCESS:
  - mem_req=1; mem_we, mem_addr and mem_wdata come from the latched command and are held constant.
  - If mem_ack=1: capture mem_rdata into the owner's rdata register, set the owner's done=1, go to RESP.
  - mem_req is 0 from the next cycle.
- RESP:
  - done is high for exactly this cycle.
  - No arbitration takes place in this cycle. Requesters drop req on the edge ending RESP, which prevents a double issue.
  - Next state is IDLE.
- d_rdata/i_rdata: hold their last value after done. For stores, d_rdata is not updated.
- Minimum latency: req seen in cycle 0 → mem_req in cycle 1 → if ack arrives in cycle 1, done in cycle 2. Back-to-back grants are therefore at most one every 3 cycles.
- Simultaneous i_req and d_req in IDLE: data wins (except under the forced-fetch rule). Fetch waits with i_req held.
- mem_ack while not in ACCESS: ignored.
- A req that drops while in ACCESS is a protocol violation; the transaction still completes.

Optional Feature:
ARB_ANTISTARVE_EN
- Defined:
  - starve_cnt (4 bits) increments on each data grant made while i_req=1.
  - It clears on any fetch grant.
  - When starve_cnt == STARVE_LIMIT and i_req=1, the next grant goes to fetch even if d_req=1.
  - starve_cnt saturates at STARVE_LIMIT.
- Undefined: strict data priority; no counter is synthesised.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding typedef: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - owner encoding: OWN_I=1'b0, OWN_D=1'b1.
- One sub-module, arb_prio_sel: a combinational selector taking i_req, d_req and force_i, and producing grant_i and grant_d. It isolates the priority/anti-starvation decision from the sequencer.

Test Plan:
- Reset: assert reset=0 mid-ACCESS, with mem_req=1 → all outputs 0 immediately; after release, state=IDLE and busy=0.
- Fetch only: i_req=1, i_addr=0x0000_0010, mem_ack one cycle after mem_req, mem_rdata=0xE3A0_0001 → i_done=1 for exactly 1 cycle, two cycles after mem_req first rises, with i_rdata=0xE3A0_0001 and mem_we=0.
- Store with wait states: d_req=1, d_we=1, d_addr=0x80, d_wdata=0xDEAD_BEEF, mem_ack delayed 3 cycles → mem_addr and mem_wdata stable for all 4 mem_req cycles; d_done pulses once; d_rdata unchanged.
- Contention: i_req and d_req rise in the same cycle → the data transaction is issued first; the fetch is issued in the IDLE following RESP; each done pulses once.
- Anti-starvation (ARB_ANTISTARVE_EN, STARVE_LIMIT=2): i_req held high, d_req continuously re-asserted → grant order D, D, I, D, D, I. Without the macro → fetch is never granted while d_req stays high.
- Protocol: mem_ack asserted in IDLE → no done pulse and no state change.
